e_mdu_ctrl: RTL and testbench
=============================

Name: e_mdu_ctrl

Overview:
- Execute-stage multiply/divide controller for the pipelined MIPS core. It sits beside the ALU.
- Sequences multi-cycle MULT/MULTU/DIV/DIVU operations and owns the HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Generates the D-stage stall request and honours exception/interrupt cancellation (req).

Parameters:
- MULT_CYCLES, 5, busy cycles for multiply ops (>=1).
- DIV_CYCLES, 10, busy cycles for divide ops (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  exception/interrupt flush; cancels the E-stage instruction this cycle.
- MDUOp  input  4  E-stage operation code (MDU_* constants).
- A  input  32  rs operand.
- B  input  32  rt operand.
- D_isMD  input  1  D-stage instruction is any MDU op.
- start  output  1  combinational; a mult/div is launched this cycle.
- busy  output  1  registered; an operation is in progress.
- stall  output  1  combinational; equals D_isMD & (start | busy).
- HIout  output  32  HI register.
- LOout  output  32  LO register.
- MDout  output  32  combinational; HI for MDU_MFHI, LO for MDU_MFLO, else 0.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, count=0, busy=0.
  - HI=0, LO=0, pending result registers=0.
- FSM states:
  - IDLE: no operation in progress.
  - RUN: counting down an operation.
- Launch and transitions:
  - start = (MDUOp in {MULT,MULTU,DIV,DIVU}) & ~req & ~busy.
  - In IDLE, start moves the FSM to RUN at the edge.
  - On that edge, count loads MULT_CYCLES or DIV_CYCLES.
  - On that same edge, the full 64-bit result is latched into pending {hi,lo}:
    - MULT: signed product. MULTU: unsigned product.
    - DIV: LO=signed quotient, HI=signed remainder (remainder takes the dividend's sign).
    - DIVU: unsigned quotient/remainder.
- Timing:
  - busy=1 for exactly N cycles after the start cycle.
  - At the edge ending the last busy cycle: HI/LO <= pending, busy->0, state->IDLE.
  - Launch at cycle T gives new HI/LO visible in cycle T+N+1.
- Divide by zero (B==0): the FSM still runs DIV_CYCLES, but HI/LO are left unchanged on completion.
- MTHI/MTLO:
  - Write HI/LO at the edge when ~req & ~busy.
  - If busy, the write is ignored. The pipeline guarantees this cannot occur, because stall holds MD ops in D.
- MFHI/MFLO: combinational read of the current registers; no stall when ~busy.
- req:
  - Suppresses start and MT writes in its cycle.
  - Does not abort an operation already in RUN; it completes and commits (architecturally issued).
- MDUOp of an MDU op while busy: ignored by this block. Only a verification bug can cause it; flag it with an assertion.
- Reset mid-operation: immediate return to IDLE; HI/LO=0; the pending result is discarded.
- stall is a pure function of current inputs and state, with no added latency.

Optional Feature:
- MDU_MADD_EN defined:
  - Adds MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU.
  - These are multiply-class ops (MULT_CYCLES).
  - pending = {HI,LO} ± product, signed or unsigned per op, mod 2^64.
  - Uses the HI/LO values present at the start cycle.
  - They count as start ops for start/stall.
- MDU_MADD_EN undefined: these codes behave as MDU_NONE (no start, no stall contribution).

Decomposition:
- defines.v (shared include) holds MDU_NONE=0, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, and the state encodings.
- One sub-module, e_mdu_calc: combinational 64-bit result from op, A, B, HI, LO.
- FSM, counter and registers live in e_mdu_ctrl.

Test Plan:
- Reset then MFHI/MFLO -> MDout=0, busy=0, stall=0.
- MULT A=0xFFFFFFFE(-2) B=3 at cycle T -> busy high T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6.
- MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
- DIV with B=0 after MTHI 0x11, MTLO 0x22 -> HI/LO unchanged.
- D_isMD=1 during busy -> stall=1 every busy cycle and 0 once idle.
- MULT with req=1 in the start cycle -> start=0, busy stays 0, HI/LO unchanged.
- req asserted mid-run -> operation still commits on schedule.
- reset asserted mid-DIV -> busy=0 and HI=LO=0 immediately, without waiting for a clock edge.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1 B=1 -> HI=1, LO=0.

Source files
------------

// File: rtl/e_mdu_ctrl_pkg.sv
// e_mdu_ctrl_pkg: MDU operation codes, FSM state type and op-class helpers.
// Optional macro MDU_MADD_EN makes MADD/MADDU/MSUB/MSUBU launchable operations.
package e_mdu_ctrl_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that occupy the unit for several cycles; with the accumulate ops
    // compiled out their codes fall through as plain no-ops.
    function automatic logic is_start_op(input logic [3:0] op);
        logic s;
        s = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
        s = s || (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return s;
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// e_mdu_calc: combinational 64-bit {HI,LO} result for every multi-cycle MDU op.
// Signed divide works on magnitudes so the most-negative dividend never overflows.
import e_mdu_ctrl_pkg::*;

module e_mdu_calc (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag;
    logic [31:0]        quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;
    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u, acc;

    // Products, quotients and the selected result, all from the current operands.
    always_comb begin
        a_neg  = a[31];
        b_neg  = b[31];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        quo_u  = '0;
        rem_u  = '0;
        quo_m  = '0;
        rem_m  = '0;
        if (b != '0) begin
            quo_u = a / b;
            rem_u = a % b;
            quo_m = a_mag / b_mag;
            rem_m = a_mag % b_mag;
        end
        quo_s  = (a_neg ^ b_neg) ? -quo_m : quo_m;
        rem_s  = a_neg ? -rem_m : rem_m;
        a_sx   = {{32{a[31]}}, a};
        b_sx   = {{32{b[31]}}, b};
        prod_s = a_sx * b_sx;
        prod_u = {32'b0, a} * {32'b0, b};
        acc    = {hi, lo};
        result = '0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV:   result = {rem_s, quo_s};
            MDU_DIVU:  result = {rem_u, quo_u};
            MDU_MADD:  result = acc + prod_s;
            MDU_MADDU: result = acc + prod_u;
            MDU_MSUB:  result = acc - prod_s;
            MDU_MSUBU: result = acc - prod_u;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: execute-stage multiply/divide sequencer owning HI/LO.
// Optional macro MDU_MADD_EN (see e_mdu_ctrl_pkg) adds the accumulate ops.
// The result is computed at launch and held in a pending register; the FSM
// only counts down and commits it, so HI/LO change exactly N+1 cycles later.
import e_mdu_ctrl_pkg::*;

module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_isMD,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HIout,
    output logic [31:0] LOout,
    output logic [31:0] MDout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [31:0]      hi, lo;
    logic [63:0]      calc_result, pending;
    logic             pending_write, commit;

    e_mdu_calc u_calc (
        .op     (MDUOp),
        .a      (A),
        .b      (B),
        .hi     (hi),
        .lo     (lo),
        .result (calc_result)
    );

    assign busy  = (state == RUN);
    assign start = is_start_op(MDUOp) & ~req & ~busy;
    assign stall = D_isMD & (start | busy);
    assign HIout = hi;
    assign LOout = lo;
    assign MDout = (MDUOp == MDU_MFHI) ? hi :
                   (MDUOp == MDU_MFLO) ? lo : '0;

    // Next state and down-counter; commit fires on the last busy cycle.
    always_comb begin
        state_next = state;
        count_next = count;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) begin
                    state_next = IDLE;
                    count_next = '0;
                    commit     = 1'b1;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // FSM state and cycle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Capture the full result at launch; a zero divisor marks it as not to be written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= '0;
            pending_write <= 1'b0;
        end else if (start) begin
            pending       <= calc_result;
            pending_write <= ~(is_div_op(MDUOp) && (B == '0));
        end
    end

    // HI/LO: committed result at the end of a run, otherwise MTHI/MTLO when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (pending_write) begin
                hi <= pending[63:32];
                lo <= pending[31:0];
            end
        end else if (!req && !busy) begin
            if (MDUOp == MDU_MTHI) hi <= A;
            if (MDUOp == MDU_MTLO) lo <= A;
        end
    end

    // A multi-cycle op reaching E while busy means the D-stage stall was bypassed.
    assert property (@(posedge clk) disable iff (reset) !(busy && is_start_op(MDUOp)))
        else $error("e_mdu_ctrl: MDU op issued while busy");

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb_e_mdu_ctrl: table-driven, hand-written and randomized checks of e_mdu_ctrl
// against a cycle-indexed behavioural model using plain 64-bit arithmetic.
import e_mdu_ctrl_pkg::*;

module tb_e_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  MDUOp = MDU_NONE;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        D_isMD = 1'b0;
    logic        start, busy, stall;
    logic [31:0] HIout, LOout, MDout;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    bit          m_pend_write;
    int          m_cyc, m_last_busy;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rq;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl[10];

    e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .D_isMD (D_isMD),
        .start  (start),
        .busy   (busy),
        .stall  (stall),
        .HIout  (HIout),
        .LOout  (LOout),
        .MDout  (MDout)
    );

    always #5 clk = ~clk;

    function automatic bit tb_is_start(input logic [3:0] op);
        bit s;
        s = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
        s = s || ((op >= 4'd9) && (op <= 4'd12));
`endif
        return s;
    endfunction

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0]        ua, ub, acc;
        sa  = 64'($signed(a));
        sb  = 64'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        acc = {hi, lo};
        case (op)
            4'd1:  return sa * sb;
            4'd2:  return ua * ub;
            4'd3: begin
                if (b == 0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return 64'd0;
                return {a % b, a / b};
            end
            4'd9:  return acc + sa * sb;
            4'd10: return acc + ua * ub;
            4'd11: return acc - sa * sb;
            4'd12: return acc - ua * ub;
            default: return 64'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_hi         = '0;
        m_lo         = '0;
        m_pend       = '0;
        m_pend_write = 1'b0;
        m_cyc        = 0;
        m_last_busy  = -1;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, b, input logic rq, dm);
        bit          busy_e, start_e, stall_e;
        logic [31:0] md_e;
        MDUOp  = op;
        A      = a;
        B      = b;
        req    = rq;
        D_isMD = dm;
        busy_e  = (m_cyc <= m_last_busy);
        start_e = tb_is_start(op) && !rq && !busy_e;
        stall_e = dm && (start_e || busy_e);
        md_e    = (op == MDU_MFHI) ? m_hi : (op == MDU_MFLO) ? m_lo : 32'd0;
        @(negedge clk);
        checkOutput("busy",  {31'b0, busy},  {31'b0, busy_e});
        checkOutput("start", {31'b0, start}, {31'b0, start_e});
        checkOutput("stall", {31'b0, stall}, {31'b0, stall_e});
        checkOutput("MDout", MDout, md_e);
        checkOutput("HIout", HIout, m_hi);
        checkOutput("LOout", LOout, m_lo);
        if (busy_e) begin
            if (m_cyc == m_last_busy && m_pend_write) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (!rq) begin
            if (op == MDU_MTHI) m_hi = a;
            if (op == MDU_MTLO) m_lo = a;
        end
        if (start_e) begin
            m_pend       = model_result(op, a, b, m_hi, m_lo);
            m_pend_write = !(((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 0));
            m_last_busy  = m_cyc + (((op == MDU_DIV) || (op == MDU_DIVU)) ? DC : MC);
        end
        @(posedge clk);
        #1;
        m_cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;

        tbl[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1] = '{MDU_MULTU, 32'hFFFFFFFE, 32'd3,        1'b0, 32'h00000002, 32'hFFFFFFFA};
        tbl[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{MDU_MTHI,  32'h00000011, 32'd0,        1'b0, 32'h00000011, 32'hFFFFFFFD};
        tbl[4] = '{MDU_MTLO,  32'h00000022, 32'd0,        1'b0, 32'h00000011, 32'h00000022};
        tbl[5] = '{MDU_DIV,   32'd5,        32'd0,        1'b0, 32'h00000011, 32'h00000022};
        tbl[6] = '{MDU_DIVU,  32'd100,      32'd7,        1'b0, 32'h00000002, 32'h0000000E};
        tbl[7] = '{MDU_MULT,  32'd9,        32'd9,        1'b1, 32'h00000002, 32'h0000000E};
        tbl[8] = '{MDU_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
        tbl[9] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};

        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset state and MFHI/MFLO");
        applyStimulus(MDU_MFHI, 32'd0, 32'd0, 1'b0, 1'b1);
        applyStimulus(MDU_MFLO, 32'd0, 32'd0, 1'b0, 1'b1);

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rq, 1'b1);
            idle(DC + 1);
            checkOutput($sformatf("tbl%0d_hi", i), HIout, tbl[i].exp_hi);
            checkOutput($sformatf("tbl%0d_lo", i), LOout, tbl[i].exp_lo);
        end

        $display("[TB] MULT busy window");
        applyStimulus(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < MC; i++) begin
            checkOutput("mult_busy", {31'b0, busy}, 32'd1);
            checkOutput("mult_hi_hold", HIout, 32'h00000000);
            applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        end
        checkOutput("mult_busy_end", {31'b0, busy}, 32'd0);
        checkOutput("mult_hi", HIout, 32'hFFFFFFFF);
        checkOutput("mult_lo", LOout, 32'hFFFFFFFA);

        $display("[TB] stall during DIV");
        applyStimulus(MDU_DIV, 32'd20, 32'd3, 1'b0, 1'b1);
        for (int i = 0; i < DC; i++) begin
            checkOutput("div_stall", {31'b0, stall}, 32'd1);
            applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        checkOutput("div_stall_end", {31'b0, stall}, 32'd0);
        checkOutput("div_lo", LOout, 32'd6);
        checkOutput("div_hi", HIout, 32'd2);

        $display("[TB] req mid-run");
        applyStimulus(MDU_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < MC; i++) applyStimulus(MDU_NONE, 32'd0, 32'd0, (i == 1), 1'b0);
        checkOutput("req_mid_hi", HIout, 32'd0);
        checkOutput("req_mid_lo", LOout, 32'd42);

        $display("[TB] reset mid-DIV");
        applyStimulus(MDU_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
        idle(3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_hi", HIout, 32'd0);
        checkOutput("rst_lo", LOout, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        idle(DC + 2);
        checkOutput("rst_hi_after", HIout, 32'd0);
        checkOutput("rst_lo_after", LOout, 32'd0);

`ifdef MDU_MADD_EN
        $display("[TB] MADDU carry into HI");
        applyStimulus(MDU_MTHI, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(MDU_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
        applyStimulus(MDU_MADDU, 32'd1, 32'd1, 1'b0, 1'b0);
        idle(MC);
        checkOutput("maddu_hi", HIout, 32'd1);
        checkOutput("maddu_lo", LOout, 32'd0);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 12));
            if ((m_cyc <= m_last_busy) && tb_is_start(op)) op = MDU_NONE;
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 :
                 ($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            applyStimulus(op, ra, rb, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        idle(DC + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
